// File: rtl/preprocess_float_quant_pkg.sv
// Shared constants and types for the float32 -> int8 input quantizer.
// Holds the fp32 field layout, int8 limits and the lane classification enum.
package preprocess_pkg;

    localparam int FP32_BIAS     = 127;
    localparam int INT8_MAX      = 127;
    localparam int INT8_MIN      = -128;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_FRAC_MSB = 22;
    localparam int FP32_FRAC_W   = 23;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_NAN,
        CLS_POSINF,
        CLS_NEGINF
    } fp_class_e;

endpackage

// File: rtl/preprocess_float_quant_if.sv
// Two-lane stream bundle: float32 input side and int8 output side with iteration tag.
// The design uses the slave view, the stimulus side uses the master view.
interface preprocess_float_quant_if #(
    parameter int ITER_W = 9
);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data0;
    logic [31:0]       in_data1;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data0;
    logic [7:0]        out_data1;
    logic [ITER_W-1:0] iter_out;
    logic              out_last;

    modport slave (
        input  in_valid, in_data0, in_data1, out_ready,
        output in_ready, out_valid, out_data0, out_data1, iter_out, out_last
    );

    modport master (
        output in_valid, in_data0, in_data1, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, iter_out, out_last
    );

endinterface

// File: rtl/preprocess_float_quant_fp32_to_int8_lane.sv
// One lane of the quantizer: stage 1 decodes the float32, stage 2 rounds half-to-even and saturates.
// The sat_o flag exists only when QUANT_SAT_STATS_EN is defined.
module fp32_to_int8_lane
    import preprocess_pkg::*;
#(
    parameter int FRAC_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data_i,
    output logic [7:0]  data_o
`ifdef QUANT_SAT_STATS_EN
    ,
    output logic        sat_o
`endif
);

    fp_class_e   cls_d, cls_q;
    logic        sign_d, sign_q;
    logic [7:0]  exp_d, exp_q;
    logic [23:0] mant_d, mant_q;

    int          e_i;
    logic [4:0]  shift;
    logic [31:0] mant_ext;
    logic        guard;
    logic        sticky;
    logic [8:0]  mag_r;
    logic [7:0]  result_c;
    logic [7:0]  data_d, data_q;

    always_comb begin
        cls_d  = cls_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        mant_d = mant_q;
        if (clr) begin
            cls_d  = CLS_ZERO;
            sign_d = 1'b0;
            exp_d  = '0;
            mant_d = '0;
        end else if (en) begin
            sign_d = data_i[FP32_SIGN_BIT];
            exp_d  = data_i[FP32_EXP_MSB:FP32_EXP_LSB];
            mant_d = {1'b1, data_i[FP32_FRAC_MSB:0]};
            if (exp_d == 8'h00) begin
                cls_d = CLS_ZERO;
            end else if (exp_d == 8'hFF) begin
                if (data_i[FP32_FRAC_MSB:0] != '0) begin
                    cls_d = CLS_NAN;
                end else begin
                    cls_d = sign_d ? CLS_NEGINF : CLS_POSINF;
                end
            end else begin
                cls_d = CLS_NORM;
            end
        end
    end

    // e is the position of the mantissa's leading one relative to the int8 LSB.
    always_comb begin
        e_i      = int'(exp_q) - FP32_BIAS + FRAC_BITS;
        mant_ext = {8'h00, mant_q};
        shift    = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        mag_r    = '0;
        result_c = '0;
        if (cls_q == CLS_POSINF) begin
            result_c = 8'(INT8_MAX);
        end else if (cls_q == CLS_NEGINF) begin
            result_c = 8'(INT8_MIN);
        end else if (cls_q == CLS_NORM) begin
            if (e_i >= 8) begin
                result_c = sign_q ? 8'(INT8_MIN) : 8'(INT8_MAX);
            end else if (e_i >= -1) begin
                shift  = 5'(FP32_FRAC_W - e_i);
                mag_r  = 9'(mant_ext >> shift);
                guard  = mant_ext[shift - 5'd1];
                sticky = |(mant_ext & ((32'd1 << (shift - 5'd1)) - 32'd1));
                mag_r  = mag_r + {8'd0, guard & (sticky | mag_r[0])};
                if (sign_q) begin
                    result_c = (mag_r >= 9'd128) ? 8'(INT8_MIN) : 8'(9'd0 - mag_r);
                end else begin
                    result_c = (mag_r > 9'd127) ? 8'(INT8_MAX) : mag_r[7:0];
                end
            end
        end
    end

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = result_c;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cls_q  <= CLS_ZERO;
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            data_q <= '0;
        end else begin
            cls_q  <= cls_d;
            sign_q <= sign_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

`ifdef QUANT_SAT_STATS_EN
    logic sat_c;
    logic sat_d, sat_q;

    // A result sitting exactly at -128 from a finite input counts as a saturation event.
    always_comb begin
        sat_c = 1'b0;
        if ((cls_q == CLS_POSINF) || (cls_q == CLS_NEGINF)) begin
            sat_c = 1'b1;
        end else if (cls_q == CLS_NORM) begin
            sat_c = (e_i >= 8) || (!sign_q && (mag_r > 9'd127)) || (sign_q && (mag_r >= 9'd128));
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (clr) begin
            sat_d = 1'b0;
        end else if (en) begin
            sat_d = sat_c;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: rtl/preprocess_float_quant.sv
// Two-lane float32 -> int8 quantizer: 2-stage valid/ready pipeline with a per-frame iteration counter.
// Defining QUANT_SAT_STATS_EN adds the sat_cnt saturation-event counter output.
module preprocess_float_quant
    import preprocess_pkg::*;
#(
    parameter int FRAC_BITS = 4,
    parameter int MAX_ITER  = 288,
    parameter int ITER_W    = 9
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    clr,
    preprocess_float_quant_if.slave bus
`ifdef QUANT_SAT_STATS_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);

    logic              stall;
    logic              advance;
    logic              fire;
    logic              valid1_d, valid1_q;
    logic              out_valid_d, out_valid_q;
    logic [ITER_W-1:0] iter_d, iter_q;
    logic              rst_done_d, rst_done_q;
    logic [7:0]        lane_data0, lane_data1;

    assign stall      = out_valid_q & ~bus.out_ready;
    assign advance    = ~stall;
    assign fire       = out_valid_q & bus.out_ready;
    assign rst_done_d = 1'b1;

`ifdef QUANT_SAT_STATS_EN
    logic        sat0, sat1;
    logic [15:0] sat_cnt_d, sat_cnt_q;
    logic [16:0] sat_sum;
`endif

    fp32_to_int8_lane #(.FRAC_BITS(FRAC_BITS)) u_lane0 (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (clr),
        .en     (advance),
        .data_i (bus.in_data0),
        .data_o (lane_data0)
`ifdef QUANT_SAT_STATS_EN
        ,
        .sat_o  (sat0)
`endif
    );

    fp32_to_int8_lane #(.FRAC_BITS(FRAC_BITS)) u_lane1 (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (clr),
        .en     (advance),
        .data_i (bus.in_data1),
        .data_o (lane_data1)
`ifdef QUANT_SAT_STATS_EN
        ,
        .sat_o  (sat1)
`endif
    );

    // clr wins over any transfer; a beat accepted in the clr cycle never reaches stage 1.
    always_comb begin
        valid1_d    = valid1_q;
        out_valid_d = out_valid_q;
        iter_d      = iter_q;
        if (clr) begin
            valid1_d    = 1'b0;
            out_valid_d = 1'b0;
            iter_d      = '0;
        end else begin
            if (advance) begin
                valid1_d    = bus.in_valid & rst_done_q;
                out_valid_d = valid1_q;
            end
            if (fire) begin
                iter_d = (iter_q == ITER_W'(MAX_ITER - 1)) ? '0 : iter_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            iter_q      <= '0;
            rst_done_q  <= 1'b0;
        end else begin
            valid1_q    <= valid1_d;
            out_valid_q <= out_valid_d;
            iter_q      <= iter_d;
            rst_done_q  <= rst_done_d;
        end
    end

    assign bus.in_ready  = advance & rst_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data0 = lane_data0;
    assign bus.out_data1 = lane_data1;
    assign bus.iter_out  = iter_q;
    assign bus.out_last  = out_valid_q & (iter_q == ITER_W'(MAX_ITER - 1));

`ifdef QUANT_SAT_STATS_EN
    always_comb begin
        sat_sum   = {1'b0, sat_cnt_q} + 17'(sat0) + 17'(sat1);
        sat_cnt_d = sat_cnt_q;
        if (clr) begin
            sat_cnt_d = '0;
        end else if (fire) begin
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_preprocess_float_quant.sv
// Scoreboard bench for preprocess_float_quant (FRAC_BITS=4): directed float32 vectors with hand-computed int8 results.
// Covers reset, latency, rounding, saturation, backpressure, frame wrap, clr and mid-stall reset; checks sat_cnt if QUANT_SAT_STATS_EN.
module tb_preprocess_float_quant;

    localparam int FRAC_BITS = 4;
    localparam int MAX_ITER  = 288;
    localparam int ITER_W    = 9;
    localparam int NVEC      = 9;

    typedef struct packed {
        logic [7:0]        d0;
        logic [7:0]        d1;
        logic [ITER_W-1:0] iter;
    } exp_t;

    typedef struct packed {
        logic [31:0] f0;
        logic [31:0] f1;
        logic [7:0]  q0;
        logic [7:0]  q1;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    logic clr   = 1'b0;

    preprocess_float_quant_if #(.ITER_W(ITER_W)) bus ();

`ifdef QUANT_SAT_STATS_EN
    logic [15:0] sat_cnt;
`endif

    preprocess_float_quant #(
        .FRAC_BITS (FRAC_BITS),
        .MAX_ITER  (MAX_ITER),
        .ITER_W    (ITER_W)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr),
        .bus   (bus)
`ifdef QUANT_SAT_STATS_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[NVEC];
    int   checks   = 0;
    int   errors   = 0;
    int   exp_iter = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and watches in_ready under stall.
    always @(negedge clk) begin
        if (rst_b && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got iter %0d, expected no beat", bus.iter_out);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("lane0", 32'(bus.out_data0), 32'(mon_e.d0));
                checkOutput("lane1", 32'(bus.out_data1), 32'(mon_e.d1));
                checkOutput("iter_out", 32'(bus.iter_out), 32'(mon_e.iter));
                checkOutput("out_last", 32'(bus.out_last), 32'(mon_e.iter == ITER_W'(MAX_ITER - 1)));
            end
        end
        if (rst_b && bus.out_valid && !bus.out_ready) begin
            checkOutput("in_ready_stall", 32'(bus.in_ready), 32'd0);
        end
    end

    task automatic applyStimulus(input int first, input int count, input int stall_start, input int stall_len);
        int   n   = 0;
        int   cyc = 0;
        vec_t v;
        while (n < count && cyc < count + 200) begin
            v             = vecs[(first + n) % NVEC];
            bus.in_valid  = 1'b1;
            bus.in_data0  = v.f0;
            bus.in_data1  = v.f1;
            bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back({v.q0, v.q1, ITER_W'(exp_iter)});
                exp_iter = (exp_iter + 1) % MAX_ITER;
                n++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (n < count) begin
            errors++;
            $display("[TB] FAIL accept_budget: accepted %0d beats, expected %0d", n, count);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (sb_q.size() != 0 && c < 50) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d beats outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic doClear();
        clr           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data0  = 32'h3F800000;
        bus.in_data1  = 32'h3F800000;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        sb_q.delete();
        exp_iter = 0;
        @(negedge clk);
        checkOutput("clr_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("clr_iter_out", 32'(bus.iter_out), 32'd0);
        checkOutput("clr_out_data0", 32'(bus.out_data0), 32'd0);
`ifdef QUANT_SAT_STATS_EN
        checkOutput("clr_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        @(negedge clk);
        checkOutput("clr_discard", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h3F800000, 32'h3F880000, 8'h10, 8'h11};
        vecs[1] = '{32'h3D000000, 32'h3DC00000, 8'h00, 8'h02};
        vecs[2] = '{32'hBDC00000, 32'h3D100000, 8'hFE, 8'h01};
        vecs[3] = '{32'h41000000, 32'hC1000000, 8'h7F, 8'h80};
        vecs[4] = '{32'h7FC00000, 32'hFF800000, 8'h00, 8'h80};
        vecs[5] = '{32'h7F800000, 32'h00400000, 8'h7F, 8'h00};
        vecs[6] = '{32'hBF800000, 32'h40F80000, 8'hF0, 8'h7C};
        vecs[7] = '{32'h3E000000, 32'h3C800000, 8'h02, 8'h00};
        vecs[8] = '{32'h40FF0000, 32'hC0FF0000, 8'h7F, 8'h80};

        bus.in_valid  = 1'b0;
        bus.in_data0  = '0;
        bus.in_data1  = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_iter_out", 32'(bus.iter_out), 32'd0);
        checkOutput("rst_out_data1", 32'(bus.out_data1), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_pre", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("in_ready_post", 32'(bus.in_ready), 32'd1);

        $display("[TB] latency");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data0 = vecs[0].f0;
        bus.in_data1 = vecs[0].f1;
        @(negedge clk);
        checkOutput("latency_accept", 32'(bus.in_ready), 32'd1);
        sb_q.push_back({vecs[0].q0, vecs[0].q1, ITER_W'(exp_iter)});
        exp_iter++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_cycle2", 32'(bus.out_valid), 32'd1);
        drain();

        $display("[TB] saturation");
        doClear();
        applyStimulus(3, 2, -1, 0);
        drain();
`ifdef QUANT_SAT_STATS_EN
        checkOutput("sat_cnt", 32'(sat_cnt), 32'd3);
`endif

        $display("[TB] all vectors");
        applyStimulus(0, NVEC, -1, 0);
        drain();

        $display("[TB] backpressure");
        applyStimulus(0, 2 * NVEC, 2, 5);
        drain();

        $display("[TB] frame wrap");
        doClear();
        applyStimulus(0, MAX_ITER + 1, -1, 0);
        drain();

        $display("[TB] clr mid-stream");
        applyStimulus(1, 100, -1, 0);
        doClear();
        applyStimulus(6, 1, -1, 0);
        drain();

        $display("[TB] reset mid-stall");
        applyStimulus(2, 2, -1, 0);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_mid_iter_out", 32'(bus.iter_out), 32'd0);
        checkOutput("rst_mid_out_data0", 32'(bus.out_data0), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef QUANT_SAT_STATS_EN
        checkOutput("rst_mid_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        sb_q.delete();
        exp_iter = 0;
        @(posedge clk);
        #1;
        rst_b         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(7, 1, -1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
